// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache refill engine.
package icache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 256;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int OFFSET_BITS    = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        WRITE
    } refill_state_t;

endpackage

// File: rtl/icache_refill_if.sv
// Miss, memory-beat and line-write signals of the refill engine, bundled as one interface.
interface icache_refill_if #(
    parameter int ADDR_W = icache_pkg::ADDR_W,
    parameter int WORD_W = icache_pkg::WORD_W,
    parameter int LINE_W = icache_pkg::LINE_W
);

    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [WORD_W-1:0] mem_rsp_data;

    logic              line_we;
    logic [ADDR_W-1:0] line_w_addr;
    logic [LINE_W-1:0] line_data;
    logic              refill_done;

    // The refill engine side.
    modport master (
        input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output miss_ready, mem_req_valid, mem_req_addr,
        output line_we, line_w_addr, line_data, refill_done
    );

    // The fetch / memory / cache-array side.
    modport slave (
        output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  miss_ready, mem_req_valid, mem_req_addr,
        input  line_we, line_w_addr, line_data, refill_done
    );

endinterface

// File: rtl/icache_line_buf.sv
// Word-indexed line assembly buffer; the stored words are presented as one flat line.
module icache_line_buf #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WORD_W-1:0]       wdata,
    output logic [WORDS*WORD_W-1:0] line
);

    logic [WORDS-1:0][WORD_W-1:0] mem;

    // NOTE: this storage is reset because its contents drive line_data, which must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign line = mem;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: fetches a line as single-word beats and writes it in one pulse.
// Define ICACHE_REFILL_CWF_EN to fetch the missing word first and wrap around the line.
module icache_refill #(
    parameter int ADDR_W = icache_pkg::ADDR_W,
    parameter int WORD_W = icache_pkg::WORD_W,
    parameter int LINE_W = icache_pkg::LINE_W
) (
    input logic            clk,
    input logic            rst_n,
    icache_refill_if.master bus
);

    import icache_pkg::*;

    localparam int BEATS = LINE_W / WORD_W;
    localparam int IDX_W = $clog2(BEATS);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = ADDR_W - OFFSET_BITS;

    refill_state_t    state, state_nxt;
    logic [TAG_W-1:0] line_addr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] start_idx;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             beat_done;

    assign accept    = (state == IDLE) && bus.miss_valid;
    assign beat_done = (state == RSP) && bus.mem_rsp_valid;

`ifdef ICACHE_REFILL_CWF_EN
    assign start_idx = bus.miss_addr[OFFSET_BITS-1 -: IDX_W];
`else
    assign start_idx = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The index wraps modulo the line on its own; line_addr stays fixed for the whole refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_addr <= '0;
            idx       <= '0;
            count     <= '0;
        end else if (accept) begin
            line_addr <= bus.miss_addr[ADDR_W-1:OFFSET_BITS];
            idx       <= start_idx;
            count     <= '0;
        end else if (beat_done) begin
            idx   <= idx + 1'b1;
            count <= count + 1'b1;
        end
    end

    // NOTE: every output and the next state get a default first so no path leaves them unassigned (no latches).
    always_comb begin
        state_nxt         = state;
        bus.miss_ready    = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.line_we       = 1'b0;
        bus.refill_done   = 1'b0;
        case (state)
            IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) state_nxt = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_nxt = RSP;
            end
            RSP: begin
                if (bus.mem_rsp_valid) begin
                    state_nxt = (count == CNT_W'(BEATS - 1)) ? WRITE : REQ;
                end
            end
            WRITE: begin
                bus.line_we     = 1'b1;
                bus.refill_done = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_req_addr = {line_addr, idx, {(OFFSET_BITS - IDX_W){1'b0}}};
    assign bus.line_w_addr  = {line_addr, {OFFSET_BITS{1'b0}}};

    icache_line_buf #(
        .WORD_W (WORD_W),
        .WORDS  (BEATS),
        .IDX_W  (IDX_W)
    ) u_line_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat_done),
        .idx   (idx),
        .wdata (bus.mem_rsp_data),
        .line  (bus.line_data)
    );

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: reset abort, in-order / critical-word-first refill, stall, busy misses.
module tb_icache_refill;

`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    icache_refill_if bus ();

    icache_refill dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          we_count = 0;
    logic [31:0] req_log[$];
    logic [31:0] data_base;
    bit          stall_en;
    bit          stray_en;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: accepts one request, answers with data_base + word index one cycle later.
    initial begin
        logic [31:0]  hold_addr;
        logic [2:0]   rsp_idx;
        logic [255:0] snap;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req_valid) begin
                if (stall_en && req_log.size() == 2) begin
                    hold_addr         = bus.mem_req_addr;
                    bus.mem_req_ready = 1'b0;
                    repeat (4) begin
                        @(negedge clk);
                        check("stall_valid", bus.mem_req_valid, 1);
                        check("stall_addr", bus.mem_req_addr, hold_addr);
                    end
                    bus.mem_req_ready = 1'b1;
                    stall_en          = 1'b0;
                end
                rsp_idx = bus.mem_req_addr[4:2];
                req_log.push_back(bus.mem_req_addr);
                if (stray_en) begin
                    snap              = bus.line_data;
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = 32'hBAD0_0BAD;
                end
                @(posedge clk);
                #1;
                if (stray_en) begin
                    check("stray_ignored", bus.line_data, snap);
                    stray_en = 1'b0;
                end
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = data_base + 32'(rsp_idx);
                @(posedge clk);
                #1;
                bus.mem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.line_we) we_count++;
        end
    end

    task automatic start_miss(input logic [31:0] addr);
        @(posedge clk);
        #1;
        bus.miss_addr  = addr;
        bus.miss_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", bus.miss_ready, 1);
    endtask

    // Cycle 0 is the accept cycle; the loop counts cycles until line_we is seen.
    task automatic wait_line(input logic [31:0] addr, input logic [31:0] base, input int exp_lat,
                             input bit hold, input logic [31:0] next_addr);
        int           cyc;
        bit           seen;
        bit           busy_ready;
        logic [255:0] exp_line;
        logic [2:0]   si;
        logic [2:0]   w;
        req_log.delete();
        data_base = base;
        @(posedge clk);
        #1;
        if (!hold) bus.miss_valid = 1'b0;
        cyc        = 1;
        seen       = 1'b0;
        busy_ready = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (bus.line_we) begin
                seen = 1'b1;
            end else begin
                if (bus.miss_ready) busy_ready = 1'b1;
                if (hold && cyc == 3) bus.miss_addr = next_addr;
                cyc++;
            end
        end
        check("line_we_seen", seen, 1);
        check("line_we_latency", cyc, exp_lat);
        check("refill_done", bus.refill_done, 1);
        check("busy_miss_ready", busy_ready, 0);
        check("line_w_addr", bus.line_w_addr, {addr[31:5], 5'b0});
        for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = base + 32'(k);
        check("line_data", bus.line_data, exp_line);
        check("req_count", req_log.size(), 8);
        si = CWF ? addr[4:2] : 3'd0;
        for (int i = 0; i < 8 && i < req_log.size(); i++) begin
            w = si + 3'(i);
            check("req_addr", req_log[i], {addr[31:5], w, 2'b00});
        end
        @(negedge clk);
        check("we_single", bus.line_we, 0);
        check("idle_ready", bus.miss_ready, 1);
    endtask

    initial begin
        int we_before;
        bus.miss_valid    = 1'b0;
        bus.miss_addr     = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        stall_en          = 1'b0;
        stray_en          = 1'b0;
        data_base         = '0;

        #1;
        check("rst_miss_ready", bus.miss_ready, 1);
        check("rst_req_valid", bus.mem_req_valid, 0);
        check("rst_line_we", bus.line_we, 0);
        check("rst_refill_done", bus.refill_done, 0);
        check("rst_line_w_addr", bus.line_w_addr, 0);
        check("rst_line_data", bus.line_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: reset while beat 3 is being answered.
        we_before = we_count;
        req_log.delete();
        data_base = 32'h1111_1100;
        start_miss(32'h0000_3000);
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
        for (int n = 0; n < 50 && req_log.size() < 4; n++) begin
            @(negedge clk);
            #1;
        end
        check("t1_beat3_reached", req_log.size() >= 4, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_miss_ready", bus.miss_ready, 1);
        check("abort_req_valid", bus.mem_req_valid, 0);
        check("abort_line_we", bus.line_we, 0);
        check("abort_line_w_addr", bus.line_w_addr, 0);
        check("abort_line_data", bus.line_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("abort_no_we", we_count - we_before, 0);
        check("late_rsp_ignored", bus.line_data, 0);
        check("late_rsp_idle", bus.mem_req_valid, 0);

        // Test 2/3: miss 0x1044, ready always high, one-cycle response.
        start_miss(32'h0000_1044);
        wait_line(32'h0000_1044, 32'hDEAD_BE00, 17, 1'b0, 32'h0);

        // Test 4: ready held low for four cycles on beat 2.
        stall_en = 1'b1;
        start_miss(32'h0000_5018);
        wait_line(32'h0000_5018, 32'hCAFE_0000, 21, 1'b0, 32'h0);
        check("stall_taken", stall_en, 0);

        // Test 5: miss held high through the refill, stray response in REQ.
        stray_en = 1'b1;
        start_miss(32'h0000_1044);
        wait_line(32'h0000_1044, 32'h1234_5600, 17, 1'b1, 32'h0000_2ABC);
        wait_line(32'h0000_2ABC, 32'h7777_0000, 17, 1'b0, 32'h0);
        check("stray_taken", stray_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
